// File: rtl/xif_result_arbiter_pkg.sv
// xif_result_arbiter_pkg: shared XIF result payload type and default widths.
package xif_arb_pkg;
  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFW_WIDTH = 32;
  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [2:0]             ecswe;
    logic [5:0]             ecsdata;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;
endpackage

// File: rtl/xif_result_arbiter_if.sv
// xif_result_arbiter_if: per-source result inputs and the single core-facing result channel.
interface xif_result_arbiter_if import xif_arb_pkg::*; #(parameter int N = 2);
  logic [N-1:0]      cp_result_valid_i;
  logic [N-1:0]      cp_result_ready_o;
  x_result_t [N-1:0] cp_result_i;
  logic              result_valid_o;
  logic              result_ready_i;
  x_result_t         result_o;
  modport master (
    output cp_result_valid_i, cp_result_i, result_ready_i,
    input  cp_result_ready_o, result_valid_o, result_o
  );
  modport slave (
    input  cp_result_valid_i, cp_result_i, result_ready_i,
    output cp_result_ready_o, result_valid_o, result_o
  );
endinterface

// File: rtl/xif_result_arbiter_rr_pick.sv
// xif_rr_pick: combinational round-robin pick, first request at or after ptr in circular order.
module xif_rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic          found;
  logic [IW-1:0] j;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/xif_result_arbiter.sv
// xif_result_arbiter: round-robin merge of coprocessor results into one registered XIF result stage.
module xif_result_arbiter import xif_arb_pkg::*; #(
  parameter int NUM_COPROC = 2
) (
  input logic clk_i,
  input logic rst_ni,
  xif_result_arbiter_if.slave xif
);
  localparam int IW = $clog2(NUM_COPROC);
  logic                  free, out_valid;
  x_result_t             out_res;
  logic [IW-1:0]         rr_q, idx;
  logic [NUM_COPROC-1:0] req, gnt;
  // Requests are masked before the pick so grants never fire into a stalled stage.
  assign free = !out_valid || xif.result_ready_i;
  assign req  = free ? xif.cp_result_valid_i : '0;
  xif_rr_pick #(.N(NUM_COPROC)) u_pick (
    .req (req),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (idx)
  );
  assign xif.cp_result_ready_o = gnt;
  assign xif.result_valid_o    = out_valid;
  assign xif.result_o          = out_res;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      rr_q      <= '0;
    end else if (free) begin
      out_valid <= |req;
      if (|req) begin
        out_res <= xif.cp_result_i[idx];
        rr_q    <= (idx == IW'(NUM_COPROC - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_xif_result_arbiter.sv
// tb_xif_result_arbiter: directed steps with a grant-order scoreboard for 2- and 3-source arbiters.
module tb_xif_result_arbiter;
  import xif_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  xif_result_arbiter_if #(.N(2)) ia ();
  xif_result_arbiter_if #(.N(3)) ib ();
  xif_result_arbiter #(.NUM_COPROC(2)) dut_a (.clk_i(clk), .rst_ni(rst_n), .xif(ia.slave));
  xif_result_arbiter #(.NUM_COPROC(3)) dut_b (.clk_i(clk), .rst_ni(rst_n), .xif(ib.slave));
  int errs = 0;
  int checks = 0;
  x_result_t qa[$], qb[$];
  x_result_t pa[2], pb[3];

  function automatic x_result_t mk(int id, logic [31:0] d);
    x_result_t r;
    r = '0;
    r.id = 4'(id);
    r.data = d;
    r.rd = 5'(id + 1);
    r.we = 1'b1;
    r.exccode = 6'(id);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic [1:0] v, input logic r);
    ia.cp_result_valid_i = v;
    ia.result_ready_i = r;
    ia.cp_result_i = {pa[1], pa[0]};
  endtask

  task automatic set_b(input logic [2:0] v, input logic r);
    ib.cp_result_valid_i = v;
    ib.result_ready_i = r;
    ib.cp_result_i = {pb[2], pb[1], pb[0]};
  endtask

  task automatic cyc_a(input string tag, input logic [1:0] eg, input logic ev);
    #1;
    chk({tag, ".rdy"}, 64'(ia.cp_result_ready_o), 64'(eg));
    chk({tag, ".vld"}, 64'(ia.result_valid_o), 64'(ev));
    if (ia.result_valid_o && ia.result_ready_i) begin
      if (qa.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL %s.sb observed=unexpected_result expected=none", tag);
      end else chk({tag, ".res"}, 64'(ia.result_o), 64'(qa.pop_front()));
    end
    for (int s = 0; s < 2; s++)
      if (eg[s]) begin
        qa.push_back(pa[s]);
        pa[s] = mk(int'(pa[s].id) + 1, pa[s].data + 32'h101);
      end
    @(posedge clk);
    #1;
    ia.cp_result_i = {pa[1], pa[0]};
  endtask

  task automatic cyc_b(input string tag, input logic [2:0] eg, input logic ev);
    #1;
    chk({tag, ".rdy"}, 64'(ib.cp_result_ready_o), 64'(eg));
    chk({tag, ".vld"}, 64'(ib.result_valid_o), 64'(ev));
    if (ib.result_valid_o && ib.result_ready_i) begin
      if (qb.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL %s.sb observed=unexpected_result expected=none", tag);
      end else chk({tag, ".res"}, 64'(ib.result_o), 64'(qb.pop_front()));
    end
    for (int s = 0; s < 3; s++)
      if (eg[s]) begin
        qb.push_back(pb[s]);
        pb[s] = mk(int'(pb[s].id) + 1, pb[s].data + 32'h202);
      end
    @(posedge clk);
    #1;
    ib.cp_result_i = {pb[2], pb[1], pb[0]};
  endtask

  initial begin
    pa[0] = mk(0, 32'h1000);
    pa[1] = mk(8, 32'h2000);
    for (int s = 0; s < 3; s++) pb[s] = mk(4 * s, 32'h100 * (s + 1));
    set_a(2'b00, 1'b1);
    set_b(3'b000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.vld", 64'(ia.result_valid_o), 64'd0);
    chk("reset.res", 64'(ia.result_o), 64'd0);
    chk("reset.rdy", 64'(ia.cp_result_ready_o), 64'd0);
    chk("reset.b_vld", 64'(ib.result_valid_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single source 1
    pa[1] = mk(3, 32'h3F80_0000);
    set_a(2'b10, 1'b1);
    cyc_a("single.c0", 2'b10, 1'b0);
    chk("single.id", 64'(ia.result_o.id), 64'd3);
    chk("single.data", 64'(ia.result_o.data), 64'h3F80_0000);
    set_a(2'b00, 1'b1);
    cyc_a("single.c1", 2'b00, 1'b1);
    cyc_a("drain", 2'b00, 1'b0);
    chk("drain.hold_id", 64'(ia.result_o.id), 64'd3);
    chk("drain.hold_data", 64'(ia.result_o.data), 64'h3F80_0000);
    // both sources continuously valid
    set_a(2'b11, 1'b1);
    cyc_a("rr.g0", 2'b01, 1'b0);
    cyc_a("rr.g1", 2'b10, 1'b1);
    cyc_a("rr.g2", 2'b01, 1'b1);
    cyc_a("rr.g3", 2'b10, 1'b1);
    set_a(2'b00, 1'b1);
    cyc_a("rr.tail", 2'b00, 1'b1);
    cyc_a("rr.idle", 2'b00, 1'b0);
    // stall with source 1 pending
    pa[0] = mk(5, 32'h55);
    set_a(2'b01, 1'b1);
    cyc_a("stall.g0", 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_a(2'b10, 1'b0);
      cyc_a($sformatf("stall.s%0d", i), 2'b00, 1'b1);
      chk($sformatf("stall.s%0d.id", i), 64'(ia.result_o.id), 64'd5);
    end
    set_a(2'b10, 1'b1);
    cyc_a("stall.release", 2'b10, 1'b1);
    set_a(2'b00, 1'b1);
    cyc_a("stall.tail", 2'b00, 1'b1);
    cyc_a("stall.idle", 2'b00, 1'b0);
    // reset while a result is stalled; pointer sits at 1 beforehand
    set_a(2'b01, 1'b1);
    cyc_a("rst.pre", 2'b01, 1'b0);
    set_a(2'b11, 1'b0);
    cyc_a("rst.stall", 2'b00, 1'b1);
    set_a(2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst.async_vld", 64'(ia.result_valid_o), 64'd0);
    chk("rst.async_res", 64'(ia.result_o), 64'd0);
    chk("rst.async_rdy", 64'(ia.cp_result_ready_o), 64'd0);
    qa.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_a(2'b11, 1'b1);
    cyc_a("rst.first", 2'b01, 1'b0);
    cyc_a("rst.second", 2'b10, 1'b1);
    set_a(2'b00, 1'b1);
    cyc_a("rst.tail", 2'b00, 1'b1);
    cyc_a("rst.idle", 2'b00, 1'b0);
    // three sources, ready pattern 1,0,1,1
    set_b(3'b111, 1'b1);
    cyc_b("n3.c0", 3'b001, 1'b0);
    set_b(3'b111, 1'b0);
    cyc_b("n3.c1", 3'b000, 1'b1);
    set_b(3'b111, 1'b1);
    cyc_b("n3.c2", 3'b010, 1'b1);
    cyc_b("n3.c3", 3'b100, 1'b1);
    set_b(3'b000, 1'b1);
    cyc_b("n3.tail", 3'b000, 1'b1);
    cyc_b("n3.idle", 3'b000, 1'b0);
    chk("sb.a_left", 64'(qa.size()), 64'd0);
    chk("sb.b_left", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/xif_result_arbiter.md
# xif_result_arbiter

Shares the single eXtension-interface result channel of the core between `NUM_COPROC` coprocessors (FPU subsystem plus further accelerators). Each coprocessor presents results independently. The block selects one per cycle by round-robin and registers it into a one-entry output stage that obeys the XIF result handshake. It sits between the coprocessor result ports and the core's `coproc_result` modport.

## Interface
Parameters:
- `NUM_COPROC`, 2: number of coprocessor result sources, ≥2.
- `X_ID_WIDTH`, 4: instruction ID width.
- `X_RFW_WIDTH`, 32: register-file write data width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `cp_result_valid_i`  in  NUM_COPROC  per-source result valid.
- `cp_result_ready_o`  out  NUM_COPROC  per-source result accepted this cycle.
- `cp_result_i`  in  NUM_COPROC × `x_result_t`  per-source result payload.
- `result_valid_o`  out  1  result valid toward core.
- `result_ready_i`  in  1  core accepts result.
- `result_o`  out  `x_result_t`  registered result payload toward core.

## Operation
- Output stage: one register, holding `out_valid` and `out_res`.
  - It is "free" when `!out_valid`, or when `out_valid && result_ready_i` (drain and refill in the same cycle).
- Arbitration applies only when the output stage is free.
  - Search starts at pointer `rr_q`.
  - The first index i in circular order with `cp_result_valid_i[i]` wins.
  - `cp_result_ready_o` is one-hot on the winner and zero elsewhere.
  - If no source is valid, or the stage is not free, all of `cp_result_ready_o` are 0.
- On grant:
  - `out_res <= cp_result_i[winner]` and `out_valid <= 1`.
  - `rr_q <= winner+1`, wrapping at `NUM_COPROC` to 0.
- Drain without grant (stage drains, no source valid): `out_valid <= 0`. `out_res` holds its value.
- Stall (`out_valid && !result_ready_i`): `out_valid`, `out_res` and `rr_q` all stay unchanged. The payload must be bit-stable while valid (XIF rule).
- `cp_result_ready_o` depends combinationally on `result_ready_i` and `cp_result_valid_i`. It must not depend on the current cycle's payload.
- Sources are expected to hold valid and payload until accepted. The arbiter does not check this.
- No ID reordering or filtering. Results are forwarded in grant order.

## Timing
- Reset: `result_valid_o`=0, `result_o`=all zeros, `cp_result_ready_o`=0, `rr_q`=0 (source 0 has first priority).
- Latency: a result granted in cycle n appears on `result_valid_o` in cycle n+1.
- Throughput: one result per cycle when `result_ready_i` is held high.
- Simultaneous drain and grant: the new payload replaces the old one at the clock edge, with no bubble.
- All sources valid and the core always ready: sources are granted 0,1,…,N-1,0,… strictly.
- Source waiting bound: a continuously valid source is granted within `NUM_COPROC` grant events.
- Reset asserted mid-transfer: outputs clear asynchronously. An in-flight result is dropped. The core and coprocessors must be reset together.

## Structure
- Shared package `xif_arb_pkg` holds:
  - `x_result_t` packed struct: `id[X_ID_WIDTH]`, `data[X_RFW_WIDTH]`, `rd[5]`, `we`, `ecswe[3]`, `ecsdata[6]`, `exc`, `exccode[6]`.
  - Default width constants.
- Sub-module `xif_rr_pick`: purely combinational. Takes a request vector and the pointer, and returns a one-hot grant and a winner index. Parameterised by N.
- Top level holds the output register and the pointer.

## Test plan
- Single source: in cycle 0, source 1 valid with id=3, data=0x3F800000, while the core is ready. Then `cp_result_ready_o`=2'b10 in cycle 0, and in cycle 1 `result_valid_o`=1 with id=3 and data=0x3F800000.
- Both sources valid continuously with the core always ready: grants alternate 0,1,0,1, starting with source 0 after reset, and `result_valid_o` stays high every cycle from cycle 1.
- Stall:
  - Source 0 result (id=5) is registered, then `result_ready_i`=0 for 4 cycles while source 1 is valid.
  - During the stall, `result_o` stays stable at id=5 and `cp_result_ready_o`=0.
  - Source 1 is granted in the cycle `result_ready_i` returns to 1.
- Back-to-back drain with no new request: `out_valid` falls one cycle after acceptance, and `result_o` retains its last value.
- Reset mid-stall: assert `rst_ni`=0 while `result_valid_o`=1. Then `result_valid_o`=0 immediately, and after release the first grant goes to source 0.
- `NUM_COPROC`=3 with all sources valid and the ready pattern 1,0,1,1: grant order is 0,1,2 with no duplicates or skips.
